// File: rtl/updown_event_monitor.sv
// updown_event_monitor: classifies up/down counter transitions into queued 6-bit event records; RANGE events need UDMON_RANGE_CHECK_EN
module updown_event_monitor #(
  parameter int CMIN  = 3,
  parameter int CMAX  = 13,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       mon_en,
  input  logic                       clear,
  input  logic [3:0]                 count,
  input  logic                       ud,
  input  logic                       load,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [5:0]                 ev_data,
  output logic [7:0]                 wrap_up_cnt,
  output logic [7:0]                 wrap_dn_cnt,
  output logic [7:0]                 drop_cnt,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     ev_level
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0] count_q;
  logic ud_q, load_q, prev_valid;
  logic [AW:0] wr_ptr, rd_ptr, rd_nxt, wr_nxt;
  logic [5:0] mem [DEPTH];
  logic [5:0] ev;
  logic ev_hit, live, up_hit, dn_hit, full, push, pop, drop;
  assign live   = mon_en && prev_valid;
  assign up_hit = live && !load_q && ud_q && count < count_q;
  assign dn_hit = live && !load_q && !ud_q && count > count_q;
  always_comb begin
    ev_hit = 1'b0;
    ev     = {2'b11, count};
    if (live) begin
      if (load_q) ev_hit = 1'b1;
      else if (up_hit) begin
        ev_hit = 1'b1;
        ev     = {2'b00, count};
      end else if (dn_hit) begin
        ev_hit = 1'b1;
        ev     = {2'b01, count};
      end
`ifdef UDMON_RANGE_CHECK_EN
      else if (count < 4'(CMIN) || count > 4'(CMAX)) begin
        ev_hit = 1'b1;
        ev     = {2'b10, count};
      end
`endif
    end
  end
  assign ev_level = wr_ptr - rd_ptr;
  assign ev_valid = ev_level != '0;
  assign full     = ev_level == (AW+1)'(DEPTH);
  assign pop      = ev_valid && ev_ready;
  assign push     = ev_hit && (!full || pop);
  assign drop     = ev_hit && full && !pop;
  assign rd_nxt   = rd_ptr + (AW+1)'(pop);
  assign wr_nxt   = wr_ptr + (AW+1)'(push);
  always_ff @(posedge clock)
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= ev;
  // ev_data is the registered head; a push into an empty slot bypasses the array
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ev_data     <= '0;
      wrap_up_cnt <= '0;
      wrap_dn_cnt <= '0;
      drop_cnt    <= '0;
      ovf         <= 1'b0;
      count_q     <= '0;
      ud_q        <= 1'b0;
      load_q      <= 1'b0;
      prev_valid  <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wrap_up_cnt <= '0;
      wrap_dn_cnt <= '0;
      drop_cnt    <= '0;
      ovf         <= 1'b0;
      prev_valid  <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (wr_nxt != rd_nxt) ev_data <= (push && rd_nxt == wr_ptr) ? ev : mem[rd_nxt[AW-1:0]];
      if (up_hit && wrap_up_cnt != 8'hff) wrap_up_cnt <= wrap_up_cnt + 8'd1;
      if (dn_hit && wrap_dn_cnt != 8'hff) wrap_dn_cnt <= wrap_dn_cnt + 8'd1;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (drop) ovf <= 1'b1;
      if (mon_en) begin
        count_q    <= count;
        ud_q       <= ud;
        load_q     <= load;
        prev_valid <= 1'b1;
      end else prev_valid <= 1'b0;
    end
endmodule
